// File: rtl/avalon_pwm_multi_if.sv
// Avalon-MM slave bus bundle for avalon_pwm_multi (word addressed, 32-bit data).
// Latency: reads return on avs_readdata one cycle after avs_read.
// Backpressure: none; the slave accepts every read and write in one cycle.
interface avalon_pwm_multi_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM with one shared prescaled counter and shadow/active register sets.
// Latency: reads 1 cycle, writes visible next cycle, pwm_out lags cnt by 1 cycle.
// Backpressure: none; optional interrupt logic under AVALON_PWM_MULTI_IRQ_EN.
module avalon_pwm_multi #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16,
  parameter int PRE_W    = 8,
  parameter int ADDR_W   = 5
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  avalon_pwm_multi_if.slave   avs,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  // Control and shadow set
  logic                en_q;
  logic [CNT_W-1:0]    period_sh_q;
  logic [PRE_W-1:0]    pre_sh_q;
  logic [CHANNELS-1:0] chen_sh_q;
  logic [CHANNELS-1:0] pol_sh_q;
  logic [CNT_W-1:0]    duty_sh_q [CHANNELS];

  // Active set, only ever loaded from the shadows on a commit
  logic [CNT_W-1:0]    period_act_q;
  logic [PRE_W-1:0]    pre_act_q;
  logic [CHANNELS-1:0] chen_act_q;
  logic [CHANNELS-1:0] pol_act_q;
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];

  logic                pend_q, pend_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                tick, wrap, commit;
  logic                wr_ctrl, wr_period, wr_pre, wr_chen, wr_pol, upd_req;
  logic [CHANNELS-1:0] wr_duty;
  logic [31:0]         wdata;

  assign wdata     = avs.avs_writedata;
  assign wr_ctrl   = avs.avs_write && (avs.avs_address == ADDR_W'(0));
  assign wr_period = avs.avs_write && (avs.avs_address == ADDR_W'(1));
  assign wr_pre    = avs.avs_write && (avs.avs_address == ADDR_W'(2));
  assign wr_chen   = avs.avs_write && (avs.avs_address == ADDR_W'(4));
  assign wr_pol    = avs.avs_write && (avs.avs_address == ADDR_W'(5));
  assign upd_req   = wr_ctrl && wdata[1];

  // Not every write-data bit lands in a register; fold them here on purpose.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  // Per-channel duty write strobes
  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_duty[i] = avs.avs_write && (avs.avs_address == ADDR_W'(6 + i));
    end
  end

  // Host-visible control bit and shadow registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      en_q        <= 1'b0;
      period_sh_q <= '0;
      pre_sh_q    <= '0;
      chen_sh_q   <= '0;
      pol_sh_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_sh_q[i] <= '0;
    end else begin
      if (wr_ctrl)   en_q        <= wdata[0];
      if (wr_period) period_sh_q <= wdata[CNT_W-1:0];
      if (wr_pre)    pre_sh_q    <= wdata[PRE_W-1:0];
      if (wr_chen)   chen_sh_q   <= wdata[CHANNELS-1:0];
      if (wr_pol)    pol_sh_q    <= wdata[CHANNELS-1:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_duty[i]) duty_sh_q[i] <= wdata[CNT_W-1:0];
      end
    end
  end

  // A pending commit lands at a period wrap, or straight away when stopped.
  assign commit = pend_q && (wrap || !en_q);

  // PEND: a fresh UPD request beats a commit on the same edge, so an UPD that
  // coincides with a wrap waits for the next one.
  always_comb begin
    pend_d = pend_q;
    if (commit)  pend_d = 1'b0;
    if (upd_req) pend_d = 1'b1;
  end

  // Pending-commit flag register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) pend_q <= 1'b0;
    else                pend_q <= pend_d;
  end

  // Active set loads from the shadows on the same edge that cnt returns to 0
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      period_act_q <= '0;
      pre_act_q    <= '0;
      chen_act_q   <= '0;
      pol_act_q    <= '0;
      for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= '0;
    end else if (commit) begin
      period_act_q <= period_sh_q;
      pre_act_q    <= pre_sh_q;
      chen_act_q   <= chen_sh_q;
      pol_act_q    <= pol_sh_q;
      for (int i = 0; i < CHANNELS; i++) duty_act_q[i] <= duty_sh_q[i];
    end
  end

  assign tick = en_q && (pre_q == pre_act_q);
  assign wrap = tick && (cnt_q == period_act_q);

  // Prescaler and period counter next state; both parked at 0 while disabled
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!en_q) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = (cnt_q == period_act_q) ? '0 : cnt_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  // Compare against the active duty; polarity flips the whole level, idle included
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (en_q && chen_act_q[i] && (cnt_q < duty_act_q[i])) ^ pol_act_q[i];
    end
  end

  // Registered PWM outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) pwm_q <= '0;
    else                pwm_q <= pwm_d;
  end

  assign pwm_out = pwm_q;

`ifdef AVALON_PWM_MULTI_IRQ_EN
  logic ie_q;
  logic wrap_q, wrap_d;
  logic wr_status;

  assign wr_status = avs.avs_write && (avs.avs_address == ADDR_W'(3));

  // Sticky WRAP: write-1-to-clear, but a wrap on the same edge wins
  always_comb begin
    wrap_d = wrap_q;
    if (wr_status && wdata[1]) wrap_d = 1'b0;
    if (wrap)                  wrap_d = 1'b1;
  end

  // Interrupt enable and WRAP flag registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ie_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= wdata[2];
      wrap_q <= wrap_d;
    end
  end

  assign irq = wrap_q && ie_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux; unused addresses and upper bits read 0, UPD always reads 0
  always_comb begin
    rdata_d = '0;
    if (avs.avs_address == ADDR_W'(0)) begin
      rdata_d[0] = en_q;
`ifdef AVALON_PWM_MULTI_IRQ_EN
      rdata_d[2] = ie_q;
`endif
    end
    if (avs.avs_address == ADDR_W'(1)) rdata_d[CNT_W-1:0]    = period_sh_q;
    if (avs.avs_address == ADDR_W'(2)) rdata_d[PRE_W-1:0]    = pre_sh_q;
    if (avs.avs_address == ADDR_W'(3)) begin
      rdata_d[0] = pend_q;
`ifdef AVALON_PWM_MULTI_IRQ_EN
      rdata_d[1] = wrap_q;
`endif
    end
    if (avs.avs_address == ADDR_W'(4)) rdata_d[CHANNELS-1:0] = chen_sh_q;
    if (avs.avs_address == ADDR_W'(5)) rdata_d[CHANNELS-1:0] = pol_sh_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (avs.avs_address == ADDR_W'(6 + i)) rdata_d[CNT_W-1:0] = duty_sh_q[i];
    end
  end

  // Read data register; holds its value between reads
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)    rdata_q <= '0;
    else if (avs.avs_read) rdata_q <= rdata_d;
  end

  assign avs.avs_readdata = rdata_q;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Directed bench for avalon_pwm_multi: register table plus PWM timing sequences.
// Latency: checks 1-cycle read return and 1-cycle output lag against cnt.
// Backpressure: none on the bus; every wait on the DUT is cycle-bounded.
module tb_avalon_pwm_multi;

  logic       clk_clk;
  logic       reset_reset_n;
  logic [7:0] pwm_out;
  logic       irq;
  int         tests;
  int         fails;
  int         cyc;

  avalon_pwm_multi_if #(.ADDR_W(5)) bus ();

  avalon_pwm_multi #(
    .CHANNELS(8), .CNT_W(16), .PRE_W(8), .ADDR_W(5)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (bus),
    .pwm_out       (pwm_out),
    .irq           (irq)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic        do_wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [4:0] a, input logic w,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.addr = a; v.do_wr = w; v.wdata = d; v.exp = e;
    vt.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_clk);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(negedge clk_clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk_clk);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(negedge clk_clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Sample one bit for n cycles: number of high samples and longest high run
  task automatic measure(input int n, input int b, output int highs, output int maxrun,
                         output logic [7:0] seen_or);
    int run;
    highs = 0; maxrun = 0; run = 0; seen_or = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_clk);
      seen_or |= pwm_out;
      if (pwm_out[b]) begin
        highs++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
    end
  endtask

  // Count cycles over n where pwm_out differs from exp
  task automatic window_const(input int n, input logic [7:0] exp, output int bad);
    bad = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_clk);
      if (pwm_out !== exp) bad++;
    end
  endtask

  task automatic wait_rise_pwm(input int b, input int bound, output int at, output logic ok);
    logic prev;
    prev = pwm_out[b]; ok = 1'b0; at = 0;
    for (int k = 0; k < bound && !ok; k++) begin
      @(negedge clk_clk);
      if (!prev && pwm_out[b]) begin ok = 1'b1; at = cyc; end
      prev = pwm_out[b];
    end
  endtask

  logic [31:0] rv;
  logic [31:0] ctrl_ie_exp;
  logic [7:0]  seen;
  logic        ok;
  int          highs, maxrun, bad, runs, run, r1, r2, b_at;
  logic        prev;

  initial begin
    tests = 0; fails = 0;
    reset_reset_n = 1'b0;
    bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0; bus.avs_read = 1'b0;
`ifdef AVALON_PWM_MULTI_IRQ_EN
    ctrl_ie_exp = 32'h4;
`else
    ctrl_ie_exp = 32'h0;
`endif

    idle(3);
    chk("reset pwm_out", {24'h0, pwm_out}, 32'h0);
    chk("reset irq", {31'h0, irq}, 32'h0);
    chk("reset readdata", bus.avs_readdata, 32'h0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;

    // Register table: reset readback of every address, then write/readback
    for (int a = 0; a < 16; a++) add(5'(a), 1'b0, 32'h0, 32'h0);
    add(5'd0,  1'b1, 32'h0000_0006, ctrl_ie_exp);
    add(5'd3,  1'b0, 32'h0,         32'h0);
    add(5'd1,  1'b1, 32'hFFFF_1234, 32'h0000_1234);
    add(5'd2,  1'b1, 32'h0000_01FF, 32'h0000_00FF);
    add(5'd3,  1'b1, 32'hFFFF_FFFF, 32'h0);
    add(5'd4,  1'b1, 32'h0000_01FF, 32'h0000_00FF);
    add(5'd5,  1'b1, 32'h0000_ABCD, 32'h0000_00CD);
    add(5'd6,  1'b1, 32'h0001_2345, 32'h0000_2345);
    add(5'd13, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF);
    add(5'd14, 1'b1, 32'h0000_DEAD, 32'h0);
    add(5'd31, 1'b1, 32'h0000_BEEF, 32'h0);
    add(5'd0,  1'b1, 32'h0,         32'h0);

    foreach (vt[i]) begin
      if (vt[i].do_wr) wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, rv);
      chk($sformatf("vec%0d addr%0d", i, vt[i].addr), rv, vt[i].exp);
    end
    chk("shadow not on outputs", {24'h0, pwm_out}, 32'h0);

    // 3-of-10 duty on channel 0
    wr(5'd1, 32'd9); wr(5'd2, 32'd0); wr(5'd6, 32'd3); wr(5'd13, 32'd0);
    wr(5'd4, 32'h01); wr(5'd5, 32'h00);
    wr(5'd0, 32'h2); wr(5'd0, 32'h1);
    idle(2);
    measure(30, 0, highs, maxrun, seen);
    chk("duty3 highs/30", highs, 9);
    chk("duty3 run", maxrun, 3);
    chk("duty3 other ch", {24'h0, seen & 8'hFE}, 32'h0);

    // Shadow duty change without UPD leaves the output alone
    wr(5'd6, 32'd7);
    measure(30, 0, highs, maxrun, seen);
    chk("no-upd highs/30", highs, 9);
    chk("no-upd run", maxrun, 3);

    // UPD just after a period start: pending until the wrap, then clean 7-wide pulses
    wait_rise_pwm(0, 40, r1, ok);
    chk("sync rise seen", {31'h0, ok}, 32'h1);
    wr(5'd0, 32'h3);
    rd(5'd3, rv);
    chk("PEND while waiting", rv, 32'h1);
    runs = 0; bad = 0; run = 0; prev = pwm_out[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_clk);
      if (pwm_out[0]) run++;
      else if (prev) begin
        runs++;
        if (run != 7) bad++;
        run = 0;
      end
      prev = pwm_out[0];
    end
    chk("upd pulse widths != 7", bad, 0);
    chk("upd closed pulses", {31'h0, runs >= 3}, 32'h1);
    rd(5'd3, rv);
    chk("PEND cleared", rv, 32'h0);

    // Inverted channel 1: duty 0 -> constant 1, duty > period -> constant 0, EN=0 -> idle 1
    wr(5'd5, 32'h02); wr(5'd4, 32'h02); wr(5'd7, 32'd0); wr(5'd0, 32'h3);
    idle(15);
    window_const(20, 8'h02, bad);
    chk("duty0 inverted bad cycles", bad, 0);
    wr(5'd7, 32'd20); wr(5'd0, 32'h3);
    idle(15);
    window_const(20, 8'h00, bad);
    chk("duty>period inverted bad cycles", bad, 0);
    wr(5'd0, 32'h0);
    idle(3);
    window_const(10, 8'h02, bad);
    chk("EN=0 idle level bad cycles", bad, 0);

    // PRESCALE=3, PERIOD=4: 20-cycle period, cnt=0 spans 4 clocks
    wr(5'd1, 32'd4); wr(5'd2, 32'd3); wr(5'd4, 32'h01); wr(5'd5, 32'h00); wr(5'd6, 32'd1);
    wr(5'd0, 32'h2); wr(5'd3, 32'h2); wr(5'd0, 32'h5);
    rd(5'd0, rv);
    chk("CTRL EN+IE readback", rv, 32'h1 | ctrl_ie_exp);
    wait_rise_pwm(0, 60, r1, ok);
    chk("presc first rise", {31'h0, ok}, 32'h1);
    measure(1, 0, highs, maxrun, seen);
    wait_rise_pwm(0, 60, r2, ok);
    chk("presc second rise", {31'h0, ok}, 32'h1);
    chk("presc period", r2 - r1, 20);
`ifdef AVALON_PWM_MULTI_IRQ_EN
    chk("irq after wrap", {31'h0, irq}, 32'h1);
    wr(5'd3, 32'h2);
    chk("irq cleared", {31'h0, irq}, 32'h0);
    ok = 1'b0; b_at = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk_clk);
      if (irq) begin ok = 1'b1; b_at = cyc; end
    end
    chk("irq re-rise seen", {31'h0, ok}, 32'h1);
    chk("irq rise vs pwm rise", b_at - r2, 19);
    chk("pwm low at irq rise", {31'h0, pwm_out[0]}, 32'h0);
    @(negedge clk_clk);
    chk("pwm high after irq rise", {31'h0, pwm_out[0]}, 32'h1);
`else
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_clk);
      if (irq !== 1'b0) bad++;
    end
    chk("irq tied low cycles", bad, 0);
    rd(5'd3, rv);
    chk("STATUS no WRAP bit", rv, 32'h0);
`endif

    // All channels forced active, then asynchronous reset mid-period
    wr(5'd1, 32'd9); wr(5'd2, 32'd0); wr(5'd4, 32'hFF); wr(5'd5, 32'h00);
    for (int i = 0; i < 8; i++) wr(5'(6 + i), 32'hFFFF);
    wr(5'd0, 32'h2); wr(5'd0, 32'h1);
    idle(5);
    chk("all channels active", {24'h0, pwm_out}, 32'hFF);
    idle(3);
    #2 reset_reset_n = 1'b0;
    #1;
    chk("async reset pwm_out", {24'h0, pwm_out}, 32'h0);
    chk("async reset irq", {31'h0, irq}, 32'h0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    rd(5'd1, rv);
    chk("PERIOD after reset", rv, 32'h0);
    rd(5'd6, rv);
    chk("DUTY0 after reset", rv, 32'h0);
    idle(5);
    chk("pwm after reset release", {24'h0, pwm_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
